// File: rtl/gth_deserializer.sv
// gth_deserializer: receive side of the 3-lane GTH pixel link.
// Each 60-bit RX word holds 20 bits per lane (two 10-bit pixels). Each lane
// searches a 40-bit window for the {SYNC_B, SYNC_A} training pair, then locks
// to that bit offset. Once all lanes lock, aligned words are split into two
// pixels that leave on consecutive cycles.
module gth_deserializer #(
   parameter logic [9:0]  SYNC_A   = 10'h17C,
   parameter logic [9:0]  SYNC_B   = 10'h283,
   parameter int unsigned LOCK_CNT = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [59:0] rx_data,
   input  logic        rx_valid,
   input  logic        align_req,
   output logic [9:0]  r,
   output logic [9:0]  g,
   output logic [9:0]  b,
   output logic        pix_valid,
   output logic        locked,
   output logic [2:0]  lane_locked,
   output logic [14:0] lane_ofs,
   output logic        overrun
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} lane_state_e;

   localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CNT);

   // Lane FSM state
   lane_state_e state_q [3];
   lane_state_e state_d [3];
   logic [4:0]  ofs_q   [3];
   logic [4:0]  ofs_d   [3];
   logic [7:0]  cnt_q   [3];
   logic [7:0]  cnt_d   [3];

   // Datapath state
   logic [19:0] prev_q  [3];
   logic [19:0] prev_d  [3];
   logic [9:0]  pix_q   [3];
   logic [9:0]  pix_d   [3];
   logic [9:0]  hold_q  [3];
   logic [9:0]  hold_d  [3];
   logic        pend_q, pend_d;
   logic        pix_valid_q, pix_valid_d;
   logic        rx_valid_q, rx_valid_d;
   logic        overrun_q, overrun_d;

   // Alignment search results
   logic [39:0] win      [3];
   logic [19:0] aw       [3];
   logic        ofs_hit  [3];
   logic        hunt_hit [3];
   logic [4:0]  hunt_ofs [3];

   function automatic logic [19:0] word_at(input logic [39:0] w, input logic [4:0] k);
      return 20'(w >> k);
   endfunction

   function automatic logic is_sync(input logic [19:0] w);
      return (w[9:0] == SYNC_A) && (w[19:10] == SYNC_B);
   endfunction

   // Build each lane's window, the word at the held offset, and the lowest matching offset
   always_comb begin
      for (int l = 0; l < 3; l++) begin
         // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
         win[l]      = {rx_data[20*l +: 20], prev_q[l]};
         aw[l]       = word_at(win[l], ofs_q[l]);
         ofs_hit[l]  = is_sync(aw[l]);
         hunt_hit[l] = 1'b0;
         hunt_ofs[l] = ofs_q[l];
         // Scan downwards so the last hit written is the lowest offset
         for (int k = 19; k >= 0; k--) begin
            if (is_sync(word_at(win[l], 5'(k)))) begin
               hunt_hit[l] = 1'b1;
               hunt_ofs[l] = 5'(k);
            end
         end
      end
   end

   // Lane FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int l = 0; l < 3; l++) begin
            state_q[l] <= HUNT;
            ofs_q[l]   <= '0;
            cnt_q[l]   <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values.
         state_q <= state_d;
         ofs_q   <= ofs_d;
         cnt_q   <= cnt_d;
      end
   end

   // Lane FSM next state: hunt for the pair, verify it, then freeze the offset
   always_comb begin
      for (int l = 0; l < 3; l++) begin
         state_d[l] = state_q[l];
         ofs_d[l]   = ofs_q[l];
         cnt_d[l]   = cnt_q[l];
         if (align_req) begin
            state_d[l] = HUNT;
            cnt_d[l]   = '0;
         end else if (rx_valid) begin
            case (state_q[l])
               HUNT: begin
                  if (hunt_hit[l]) begin
                     ofs_d[l]   = hunt_ofs[l];
                     cnt_d[l]   = 8'd1;
                     state_d[l] = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                  end
               end
               VERIFY: begin
                  if (ofs_hit[l]) begin
                     cnt_d[l] = cnt_q[l] + 8'd1;
                     if (cnt_q[l] + 8'd1 == LOCK_TARGET) state_d[l] = LOCKED;
                  end else begin
                     state_d[l] = HUNT;
                     cnt_d[l]   = '0;
                  end
               end
               default: ;  // LOCKED: offset frozen, video content is not checked
            endcase
         end
      end
   end

   // Lane FSM outputs: per-lane lock flags and offsets
   always_comb begin
      for (int l = 0; l < 3; l++) begin
         lane_locked[l]     = (state_q[l] == LOCKED);
         lane_ofs[5*l +: 5] = ofs_q[l];
      end
      locked = &lane_locked;
   end

   // Pixel path: p0 follows a locked rx_valid, the held p1 fills the next cycle
   always_comb begin
      prev_d      = prev_q;
      pix_d       = pix_q;
      hold_d      = hold_q;
      pend_d      = pend_q;
      pix_valid_d = 1'b0;
      rx_valid_d  = rx_valid;
      overrun_d   = overrun_q | (rx_valid & rx_valid_q);
      if (rx_valid) begin
         for (int l = 0; l < 3; l++) prev_d[l] = rx_data[20*l +: 20];
      end
      if (align_req) begin
         pend_d    = 1'b0;
         overrun_d = 1'b0;
      end else if (rx_valid && locked) begin
         // A back-to-back word overwrites any pending p1 here
         for (int l = 0; l < 3; l++) begin
            pix_d[l]  = aw[l][9:0];
            hold_d[l] = aw[l][19:10];
         end
         pend_d      = 1'b1;
         pix_valid_d = 1'b1;
      end else if (pend_q) begin
         pix_d       = hold_q;
         pend_d      = 1'b0;
         pix_valid_d = 1'b1;
      end
   end

   // Pixel path registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: prev words seed the first window after reset, so these arrays are reset too.
         for (int l = 0; l < 3; l++) begin
            prev_q[l] <= '0;
            pix_q[l]  <= '0;
            hold_q[l] <= '0;
         end
         pend_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         pix_q       <= pix_d;
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         pix_valid_q <= pix_valid_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign r         = pix_q[0];
   assign g         = pix_q[1];
   assign b         = pix_q[2];
   assign pix_valid = pix_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_gth_deserializer.sv
// tb_gth_deserializer: directed vectors for lock, alignment, retrain,
// overrun and asynchronous reset of gth_deserializer.
module tb_gth_deserializer;

   localparam logic [19:0] TRAIN = {10'h283, 10'h17C};

   logic        clk = 1'b0;
   logic        resetn;
   logic [59:0] rx_data;
   logic        rx_valid;
   logic        align_req;
   logic [9:0]  r, g, b;
   logic        pix_valid, locked, overrun;
   logic [2:0]  lane_locked;
   logic [14:0] lane_ofs;

   int checks = 0;
   int errors = 0;

   // Transmitted word history and injected bit offset per lane
   logic [19:0] tx_prev [3];
   int          lane_k  [3];

   typedef struct {
      logic [19:0] wr, wg, wb;   // transmitted lane words {p1, p0}
      logic [30:0] exp1;         // {pix_valid, r, g, b} one cycle after rx_valid
      logic [30:0] exp2;         // {pix_valid, r, g, b} two cycles after rx_valid
   } vec_t;

   vec_t tbl [3];

   gth_deserializer dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .align_req   (align_req),
      .r           (r),
      .g           (g),
      .b           (b),
      .pix_valid   (pix_valid),
      .locked      (locked),
      .lane_locked (lane_locked),
      .lane_ofs    (lane_ofs),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Received lane bits for a transmitter stream delayed so that the aligned
   // word sits at offset k of the {cur, prev} window
   function automatic logic [19:0] lane_bits(input logic [19:0] cur_w, input logic [19:0] prev_w,
                                             input int k);
      logic [39:0] pair;
      pair = {cur_w, prev_w};
      return 20'(pair >> (20 - k));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [19:0] w0, input logic [19:0] w1, input logic [19:0] w2);
      logic [19:0] w [3];
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      for (int l = 0; l < 3; l++) begin
         rx_data[20*l +: 20] = lane_bits(w[l], tx_prev[l], lane_k[l]);
         tx_prev[l] = w[l];
      end
      rx_valid = 1'b1;
   endtask

   // One word then one idle cycle; returns the pixel outputs after each
   task automatic push(input logic [19:0] w0, input logic [19:0] w1, input logic [19:0] w2,
                       output logic [30:0] o1, output logic [30:0] o2);
      load(w0, w1, w2);
      tick();
      o1 = {pix_valid, r, g, b};
      rx_valid = 1'b0;
      tick();
      o2 = {pix_valid, r, g, b};
   endtask

   task automatic train(input int n, output logic pv_seen);
      logic [30:0] o1, o2;
      pv_seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         push(TRAIN, TRAIN, TRAIN, o1, o2);
         pv_seen = pv_seen | o1[30] | o2[30];
      end
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      rx_valid = 1'b0;
      for (int l = 0; l < 3; l++) tx_prev[l] = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic run_table(input string tag);
      logic [30:0] o1, o2;
      for (int i = 0; i < 3; i++) begin
         push(tbl[i].wr, tbl[i].wg, tbl[i].wb, o1, o2);
         check($sformatf("%s vec%0d p0", tag, i), 64'(o1), 64'(tbl[i].exp1));
         check($sformatf("%s vec%0d p1", tag, i), 64'(o2), 64'(tbl[i].exp2));
      end
   endtask

   initial begin
      logic        pv;
      logic [30:0] o1, o2;

      // Each row's outputs are the pixels of the previously transmitted word
      tbl[0] = '{wr: {10'h0AA, 10'h155}, wg: {10'h3FF, 10'h000}, wb: {10'h123, 10'h2DC},
                 exp1: {1'b1, 10'h17C, 10'h17C, 10'h17C}, exp2: {1'b1, 10'h283, 10'h283, 10'h283}};
      tbl[1] = '{wr: {10'h001, 10'h200}, wg: {10'h155, 10'h0AA}, wb: {10'h0F0, 10'h30F},
                 exp1: {1'b1, 10'h155, 10'h000, 10'h2DC}, exp2: {1'b1, 10'h0AA, 10'h3FF, 10'h123}};
      tbl[2] = '{wr: {10'h111, 10'h222}, wg: {10'h333, 10'h044}, wb: {10'h055, 10'h066},
                 exp1: {1'b1, 10'h200, 10'h0AA, 10'h30F}, exp2: {1'b1, 10'h001, 10'h155, 10'h0F0}};

      rx_data   = '0;
      rx_valid  = 1'b0;
      align_req = 1'b0;
      resetn    = 1'b0;
      for (int l = 0; l < 3; l++) begin
         tx_prev[l] = '0;
         lane_k[l]  = 0;
      end

      // Reset state
      tick();
      tick();
      check("rst pixels", 64'({pix_valid, r, g, b}), 64'(0));
      check("rst locked", 64'(locked), 64'(0));
      check("rst lane_locked", 64'(lane_locked), 64'(0));
      check("rst lane_ofs", 64'(lane_ofs), 64'(0));
      check("rst overrun", 64'(overrun), 64'(0));
      resetn = 1'b1;

      // Lock at offset 0: matches start on the second word, lock on the ninth
      train(8, pv);
      check("t1 not yet locked", 64'(lane_locked), 64'(0));
      train(1, pv);
      check("t1 lane_locked", 64'(lane_locked), 64'(3'b111));
      check("t1 locked", 64'(locked), 64'(1));
      check("t1 lane_ofs", 64'(lane_ofs), 64'(0));
      check("t1 no pixels in training", 64'(pv), 64'(0));
      run_table("t1");

      // Back-to-back rx_valid while locked
      load({10'h3AB, 10'h0CD}, {10'h2EF, 10'h101}, {10'h010, 10'h3C3});
      tick();
      check("t5 p0 prev word", 64'({pix_valid, r, g, b}), 64'({1'b1, 10'h222, 10'h044, 10'h066}));
      check("t5 no overrun yet", 64'(overrun), 64'(0));
      load({10'h1E1, 10'h21E}, {10'h0F0, 10'h00F}, {10'h2A5, 10'h15A});
      tick();
      check("t5 p0 replaces p1", 64'({pix_valid, r, g, b}), 64'({1'b1, 10'h0CD, 10'h101, 10'h3C3}));
      check("t5 overrun set", 64'(overrun), 64'(1));
      rx_valid = 1'b0;
      tick();
      check("t5 p1 second word", 64'({pix_valid, r, g, b}), 64'({1'b1, 10'h3AB, 10'h2EF, 10'h010}));
      tick();
      check("t5 idle holds", 64'({pix_valid, r, g, b}), 64'({1'b0, 10'h3AB, 10'h2EF, 10'h010}));
      check("t5 overrun sticky", 64'(overrun), 64'(1));

      // align_req during the p1 cycle
      load(20'h0, 20'h0, 20'h0);
      tick();
      check("t4 p0 before align", 64'({pix_valid, r, g, b}), 64'({1'b1, 10'h21E, 10'h00F, 10'h15A}));
      rx_valid  = 1'b0;
      align_req = 1'b1;
      tick();
      align_req = 1'b0;
      check("t4 pixels after align", 64'({pix_valid, r, g, b}), 64'({1'b0, 10'h21E, 10'h00F, 10'h15A}));
      check("t4 locked after align", 64'(locked), 64'(0));
      check("t4 lane_locked after align", 64'(lane_locked), 64'(0));
      check("t4 overrun cleared", 64'(overrun), 64'(0));
      train(8, pv);
      check("t4 relock pending", 64'(lane_locked), 64'(0));
      train(1, pv);
      check("t4 relocked", 64'(lane_locked), 64'(3'b111));
      check("t4 no pixels in training", 64'(pv), 64'(0));

      // Independent lane offsets 7/0/19
      do_reset();
      lane_k[0] = 7;
      lane_k[1] = 0;
      lane_k[2] = 19;
      train(8, pv);
      check("t2 not yet locked", 64'(locked), 64'(0));
      train(1, pv);
      check("t2 lane_ofs", 64'(lane_ofs), 64'(15'b10011_00000_00111));
      check("t2 locked", 64'(locked), 64'(1));
      run_table("t2");

      // Corrupted word on g during verify
      do_reset();
      for (int l = 0; l < 3; l++) lane_k[l] = 0;
      train(5, pv);
      push(TRAIN, 20'h0, TRAIN, o1, o2);
      train(1, pv);
      check("t3 after corrupt", 64'(lane_locked), 64'(0));
      train(2, pv);
      check("t3 r/b locked g hunting", 64'(lane_locked), 64'(3'b101));
      check("t3 locked low", 64'(locked), 64'(0));
      train(5, pv);
      check("t3 g one short", 64'(lane_locked), 64'(3'b101));
      train(1, pv);
      check("t3 g relocked", 64'(lane_locked), 64'(3'b111));
      check("t3 locked", 64'(locked), 64'(1));

      // Asynchronous reset mid-output
      load(tbl[0].wr, tbl[0].wg, tbl[0].wb);
      tick();
      check("t6 output active", 64'({pix_valid, r, g, b}), 64'({1'b1, 10'h17C, 10'h17C, 10'h17C}));
      rx_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      check("t6 async pixels", 64'({pix_valid, r, g, b}), 64'(0));
      check("t6 async lock", 64'({locked, lane_locked}), 64'(0));
      check("t6 async lane_ofs", 64'(lane_ofs), 64'(0));
      do_reset();

      // Asynchronous reset mid-verify, then a full fresh hunt
      train(3, pv);
      #2;
      resetn = 1'b0;
      #1;
      check("t6 verify reset", 64'({pix_valid, locked, lane_locked}), 64'(0));
      do_reset();
      train(8, pv);
      check("t6 fresh hunt pending", 64'(lane_locked), 64'(0));
      train(1, pv);
      check("t6 fresh lock", 64'(lane_locked), 64'(3'b111));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
